// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and state encoding for the FIR coefficient loader
// Purpose : coefficient width, tap count, tap-counter width and FSM state type
//           shared by fir_reg and fir_coeff_loader.
// Ports   : none (package).
package fir_pkg;

   localparam int NB    = 12;
   localparam int NTAPS = 9;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_LOAD   = 2'b01,
      ST_COMMIT = 2'b10
   } state_e;

   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NTAPS - 1);

endpackage

// File: rtl/fir_reg.sv
// rtl/fir_reg.sv - W-bit register with load enable and asynchronous active-low reset
// Purpose : one coefficient word of storage (shadow or active bank).
// Ports   : CLK   in  1  clock
//           RST_n in  1  async active-low reset, clears q_o
//           en_i  in  1  load d_i on the next rising edge
//           d_i   in  W  next value
//           q_o   out W  stored value
module fir_reg #(
   parameter int W = 12
) (
   input  logic         CLK,
   input  logic         RST_n,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] data_q;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - serial loader and double buffer for the 9-tap FIR coefficient set
// Purpose : collects nine serial words into a shadow bank and copies the whole
//           bank to the active outputs in one commit cycle, so the FIR never
//           sees a partially updated set.
// Ports   : CLK     in  1   clock
//           RST_n   in  1   async active-low reset
//           CSTART  in  1   pulse: start (or restart) a coefficient load
//           CIN     in  NB  serial coefficient word, first -> B0
//           CVIN    in  1   CIN valid
//           B0..B8  out NB  active coefficient set
//           BVALID  out 1   a full set has been committed since reset
//           BUSY    out 1   load in progress (registered decode of state)
//           ERR     out 1   sticky protocol error, cleared by an accepted CSTART
module fir_coeff_loader
   import fir_pkg::*;
(
   input  logic          CLK,
   input  logic          RST_n,
   input  logic          CSTART,
   input  logic [NB-1:0] CIN,
   input  logic          CVIN,
   output logic [NB-1:0] B0,
   output logic [NB-1:0] B1,
   output logic [NB-1:0] B2,
   output logic [NB-1:0] B3,
   output logic [NB-1:0] B4,
   output logic [NB-1:0] B5,
   output logic [NB-1:0] B6,
   output logic [NB-1:0] B7,
   output logic [NB-1:0] B8,
   output logic          BVALID,
   output logic          BUSY,
   output logic          ERR
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             bvalid_q;
   logic             busy_q;
   logic             err_q;

   logic [NB-1:0]    shadow_w [NTAPS];
   logic [NB-1:0]    active_w [NTAPS];
   logic [NTAPS-1:0] shadow_we;
   logic             commit_we;

   // A word is only captured in LOAD; a CSTART in the same cycle discards it.
   logic             capture;
   assign capture   = (state_q == ST_LOAD) && CVIN && !CSTART;
   assign commit_we = (state_q == ST_COMMIT);

   for (genvar i = 0; i < NTAPS; i++) begin : g_tap
      assign shadow_we[i] = capture && (cnt_q == CNT_W'(i));

      fir_reg #(.W(NB)) u_shadow (
         .CLK   (CLK),
         .RST_n (RST_n),
         .en_i  (shadow_we[i]),
         .d_i   (CIN),
         .q_o   (shadow_w[i])
      );

      fir_reg #(.W(NB)) u_active (
         .CLK   (CLK),
         .RST_n (RST_n),
         .en_i  (commit_we),
         .d_i   (shadow_w[i]),
         .q_o   (active_w[i])
      );
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         // BUSY follows the state one edge late so it drops two edges after
         // the last word, matching the commit-then-idle sequence.
         busy_q <= (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (CSTART) begin
                  state_q <= ST_LOAD;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
               end else if (CVIN) begin
                  err_q <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (CSTART) begin
                  // Restart: the partial shadow contents are simply overwritten.
                  cnt_q <= '0;
                  err_q <= 1'b1;
               end else if (CVIN) begin
                  if (cnt_q == LAST_TAP) begin
                     state_q <= ST_COMMIT;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            ST_COMMIT: begin
               bvalid_q <= 1'b1;
               if (CSTART) begin
                  state_q <= ST_LOAD;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
               end else begin
                  state_q <= ST_IDLE;
                  if (CVIN) begin
                     err_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign B0     = active_w[0];
   assign B1     = active_w[1];
   assign B2     = active_w[2];
   assign B3     = active_w[3];
   assign B4     = active_w[4];
   assign B5     = active_w[5];
   assign B6     = active_w[6];
   assign B7     = active_w[7];
   assign B8     = active_w[8];
   assign BVALID = bvalid_q;
   assign BUSY   = busy_q;
   assign ERR    = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb/tb_fir_coeff_loader.sv - self-checking bench for fir_coeff_loader
module tb_fir_coeff_loader;

   logic        CLK = 1'b0;
   logic        RST_n = 1'b0;
   logic        CSTART = 1'b0;
   logic [11:0] CIN = '0;
   logic        CVIN = 1'b0;
   logic [11:0] B0, B1, B2, B3, B4, B5, B6, B7, B8;
   logic        BVALID, BUSY, ERR;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   fir_coeff_loader dut (
      .CLK(CLK), .RST_n(RST_n), .CSTART(CSTART), .CIN(CIN), .CVIN(CVIN),
      .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6), .B7(B7), .B8(B8),
      .BVALID(BVALID), .BUSY(BUSY), .ERR(ERR)
   );

   logic [11:0] b_dut [9];
   assign b_dut[0] = B0;
   assign b_dut[1] = B1;
   assign b_dut[2] = B2;
   assign b_dut[3] = B3;
   assign b_dut[4] = B4;
   assign b_dut[5] = B5;
   assign b_dut[6] = B6;
   assign b_dut[7] = B7;
   assign b_dut[8] = B8;

   // Reference model: transaction-level view of the loader.
   logic [11:0] act_m [9];
   logic [11:0] pend_set [9];
   logic [11:0] words_q [$];
   bit          loading_m, pend_m, bvalid_m, busy_m, err_m;

   task automatic reset_model();
      for (int i = 0; i < 9; i++) act_m[i] = '0;
      words_q.delete();
      loading_m = 0; pend_m = 0; bvalid_m = 0; busy_m = 0; err_m = 0;
   endtask

   // One clock: drive inputs at negedge, advance model at posedge, return at next negedge.
   task automatic step(input bit cs, input bit cv, input logic [11:0] ci);
      bit was_busy;
      CSTART = cs; CVIN = cv; CIN = ci;
      @(posedge CLK);
      was_busy = loading_m || pend_m;
      if (pend_m) begin
         for (int i = 0; i < 9; i++) act_m[i] = pend_set[i];
         bvalid_m = 1; pend_m = 0;
         if (cs) begin loading_m = 1; words_q.delete(); err_m = 0; end
         else if (cv) err_m = 1;
      end else if (loading_m) begin
         if (cs) begin words_q.delete(); err_m = 1; end
         else if (cv) begin
            words_q.push_back(ci);
            if (words_q.size() == 9) begin
               for (int i = 0; i < 9; i++) pend_set[i] = words_q[i];
               words_q.delete(); pend_m = 1; loading_m = 0;
            end
         end
      end else begin
         if (cs) begin loading_m = 1; words_q.delete(); err_m = 0; end
         else if (cv) err_m = 1;
      end
      busy_m = was_busy;
      @(negedge CLK);
      CSTART = 0; CVIN = 0; CIN = $urandom;
   endtask

   task automatic test_reset();
      RST_n = 0; reset_model();
      repeat (3) @(negedge CLK);
      RST_n = 1;
      repeat (5) step(0, 0, 12'h0);
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (b_dut[i] !== 12'h000) begin
            errors++; $display("FAIL reset_B%0d got %h exp 000", i, b_dut[i]);
         end
      end
      checks++;
      if ({BVALID, BUSY, ERR} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got %b exp 000", {BVALID, BUSY, ERR});
      end
   endtask

   task automatic test_basic();
      logic [11:0] w [9];
      w = '{12'hFFF, 12'hFFE, 12'h004, 12'h008, 12'h010, 12'h008, 12'h004, 12'hFFE, 12'hFFF};
      step(1, 0, 12'h0);
      for (int i = 0; i < 9; i++) step(0, 1, w[i]);
      checks++;
      if (B0 !== 12'h000 || BVALID !== 1'b0) begin
         errors++; $display("FAIL basic_early B0=%h BVALID=%b exp 000/0", B0, BVALID);
      end
      step(0, 0, 12'h0);
      checks++;
      if (B0 !== 12'hFFF || B4 !== 12'h010 || B8 !== 12'hFFF) begin
         errors++; $display("FAIL basic_B got %h %h %h exp fff 010 fff", B0, B4, B8);
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (b_dut[i] !== w[i]) begin
            errors++; $display("FAIL basic_B%0d got %h exp %h", i, b_dut[i], w[i]);
         end
      end
      checks++;
      if ({BVALID, ERR, BUSY} !== 3'b101) begin
         errors++; $display("FAIL basic_flags got %b exp 101", {BVALID, ERR, BUSY});
      end
      step(0, 0, 12'h0);
      checks++;
      if (BUSY !== 1'b0) begin
         errors++; $display("FAIL basic_busy_drop got %b exp 0", BUSY);
      end
   endtask

   task automatic test_gaps();
      logic [11:0] prev [9];
      for (int i = 0; i < 9; i++) prev[i] = act_m[i];
      step(1, 0, 12'h0);
      for (int w = 1; w <= 9; w++) begin
         step(0, 1, 12'(w));
         if (w < 9) begin
            for (int g = 0; g < 2 + int'($urandom_range(0, 1)); g++) begin
               step(0, 0, $urandom);
               for (int i = 0; i < 9; i++) begin
                  checks++;
                  if (b_dut[i] !== prev[i]) begin
                     errors++; $display("FAIL gaps_hold_B%0d got %h exp %h", i, b_dut[i], prev[i]);
                  end
               end
            end
         end
      end
      checks++;
      if (B8 !== prev[8]) begin
         errors++; $display("FAIL gaps_pre_commit B8 got %h exp %h", B8, prev[8]);
      end
      step(0, 0, 12'h0);
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (b_dut[i] !== 12'(i + 1)) begin
            errors++; $display("FAIL gaps_B%0d got %h exp %h", i, b_dut[i], 12'(i + 1));
         end
      end
      step(0, 0, 12'h0);
   endtask

   task automatic test_abort();
      bit saw_bad = 0;
      step(1, 0, 12'h0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 12'(100 + i));
         for (int j = 0; j < 9; j++) if (b_dut[j] >= 12'd100 && b_dut[j] <= 12'd103) saw_bad = 1;
      end
      step(1, 1, 12'd555);
      checks++;
      if (ERR !== 1'b1) begin
         errors++; $display("FAIL abort_err got %b exp 1", ERR);
      end
      for (int i = 0; i < 9; i++) begin
         step(0, 1, 12'(200 + i));
         for (int j = 0; j < 9; j++) if (b_dut[j] >= 12'd100 && b_dut[j] <= 12'd103) saw_bad = 1;
      end
      step(0, 0, 12'h0);
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (b_dut[i] !== 12'(200 + i)) begin
            errors++; $display("FAIL abort_B%0d got %h exp %h", i, b_dut[i], 12'(200 + i));
         end
      end
      checks++;
      if (saw_bad || BVALID !== 1'b1) begin
         errors++; $display("FAIL abort_partial saw_partial=%0d BVALID=%b exp 0/1", saw_bad, BVALID);
      end
      step(0, 0, 12'h0);
   endtask

   task automatic test_idle_cvin();
      logic [11:0] prev [9];
      for (int i = 0; i < 9; i++) prev[i] = b_dut[i];
      step(0, 1, 12'h7FF);
      checks++;
      if (ERR !== 1'b1) begin
         errors++; $display("FAIL idle_cvin_err got %b exp 1", ERR);
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (b_dut[i] !== prev[i]) begin
            errors++; $display("FAIL idle_cvin_B%0d got %h exp %h", i, b_dut[i], prev[i]);
         end
      end
      step(1, 0, 12'h0);
      checks++;
      if (ERR !== 1'b0) begin
         errors++; $display("FAIL idle_cstart_clr got %b exp 0", ERR);
      end
      for (int i = 0; i < 9; i++) step(0, 1, $urandom);
      step(0, 0, 12'h0);
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (b_dut[i] !== act_m[i]) begin
            errors++; $display("FAIL idle_reload_B%0d got %h exp %h", i, b_dut[i], act_m[i]);
         end
      end
      step(0, 0, 12'h0);
   endtask

   task automatic test_reset_mid();
      step(1, 0, 12'h0);
      for (int i = 0; i < 5; i++) step(0, 1, $urandom);
      RST_n = 0;
      #1;
      reset_model();
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (b_dut[i] !== 12'h000) begin
            errors++; $display("FAIL rstmid_B%0d got %h exp 000", i, b_dut[i]);
         end
      end
      checks++;
      if ({BVALID, BUSY, ERR} !== 3'b000) begin
         errors++; $display("FAIL rstmid_flags got %b exp 000", {BVALID, BUSY, ERR});
      end
      @(negedge CLK);
      @(negedge CLK);
      RST_n = 1;
      step(1, 0, 12'h0);
      for (int i = 0; i < 9; i++) step(0, 1, $urandom);
      step(0, 0, 12'h0);
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (b_dut[i] !== act_m[i]) begin
            errors++; $display("FAIL rstmid_reload_B%0d got %h exp %h", i, b_dut[i], act_m[i]);
         end
      end
      checks++;
      if (BVALID !== 1'b1) begin
         errors++; $display("FAIL rstmid_bvalid got %b exp 1", BVALID);
      end
      step(0, 0, 12'h0);
   endtask

   task automatic test_back_to_back();
      step(1, 0, 12'h0);
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 9; i++) step(0, 1, $urandom);
         step(s < 2, 0, 12'h0);
         for (int i = 0; i < 9; i++) begin
            checks++;
            if (b_dut[i] !== act_m[i]) begin
               errors++; $display("FAIL b2b_set%0d_B%0d got %h exp %h", s, i, b_dut[i], act_m[i]);
            end
         end
         checks++;
         if ({BVALID, BUSY, ERR} !== {bvalid_m, busy_m, err_m}) begin
            errors++; $display("FAIL b2b_flags%0d got %b exp %b", s, {BVALID, BUSY, ERR}, {bvalid_m, busy_m, err_m});
         end
      end
      step(0, 0, 12'h0);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, $urandom);
         for (int i = 0; i < 9; i++) begin
            checks++;
            if (b_dut[i] !== act_m[i]) begin
               errors++; $display("FAIL rand_c%0d_B%0d got %h exp %h", c, i, b_dut[i], act_m[i]);
            end
         end
         checks++;
         if ({BVALID, BUSY, ERR} !== {bvalid_m, busy_m, err_m}) begin
            errors++; $display("FAIL rand_c%0d_flags got %b exp %b", c, {BVALID, BUSY, ERR}, {bvalid_m, busy_m, err_m});
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_abort();
      test_idle_cvin();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
